// File: rtl/mouse_axis_emu.sv
// mouse_axis_emu: turns PS/2 mouse packets into saturating signed X/Y axes,
// hands control back to the analog joystick when it is deflected past a dead
// zone, and reports the mouse buttons while the mouse is in control.
// Datapath: event detect -> stage 1 (scaled/clamped deltas) -> stage 2
// (saturating accumulate, registered outputs). Two cycles from strobe to
// output, one packet accepted per cycle, no stall.
module mouse_axis_emu #(
  parameter int AXIS_W    = 8,
  parameter int STEP_MAX  = 10,
  parameter int DEAD_ZONE = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [24:0]       ps2_mouse,
  input  logic [15:0]       joya,
  input  logic [1:0]        sens,
  input  logic              invert_y,
  input  logic              recenter,
  output logic [AXIS_W-1:0] ax,
  output logic [AXIS_W-1:0] ay,
  output logic [2:0]        btn,
  output logic              mouse_active,
  output logic              upd
);

  // The sum must hold an AXIS_W accumulator plus an 11-bit delta without wrap.
  localparam int SUM_W = ((AXIS_W > 11) ? AXIS_W : 11) + 1;

  localparam logic signed [10:0]      STEP_P  = 11'(STEP_MAX);
  localparam logic signed [10:0]      STEP_N  = 11'(-STEP_MAX);
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (AXIS_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(2 ** (AXIS_W - 1)));
  localparam logic [8:0]              DZ      = 9'(DEAD_ZONE);

  typedef enum logic [0:0] {
    ST_JOY   = 1'b0,
    ST_MOUSE = 1'b1
  } state_t;

  // Build one signed delta: overflow forces full step, optional negate,
  // sensitivity scaling (arithmetic shifts floor toward -inf), then clamp.
  function automatic logic signed [10:0] form_delta(
    input logic       sign,
    input logic [7:0] mag,
    input logic       ovf,
    input logic       neg,
    input logic [1:0] sel
  );
    logic signed [10:0] v;
    logic signed [10:0] s;
    if (ovf) begin
      v = sign ? STEP_N : STEP_P;
    end else begin
      v = {{3{sign}}, mag};
    end
    if (neg) begin
      v = -v;
    end else begin
      v = v;
    end
    case (sel)
      2'd0:    s = v;
      2'd1:    s = v <<< 1;
      2'd2:    s = v >>> 1;
      2'd3:    s = v >>> 2;
      default: s = v;
    endcase
    if (s > STEP_P) begin
      return STEP_P;
    end else if (s < STEP_N) begin
      return STEP_N;
    end else begin
      return s;
    end
  endfunction

  // Saturating accumulate into the signed AXIS_W range.
  function automatic logic signed [AXIS_W-1:0] sat_add(
    input logic signed [AXIS_W-1:0] acc,
    input logic signed [10:0]       d
  );
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(d);
    if (sum > ACC_MAX) begin
      return ACC_MAX[AXIS_W-1:0];
    end else if (sum < ACC_MIN) begin
      return ACC_MIN[AXIS_W-1:0];
    end else begin
      return sum[AXIS_W-1:0];
    end
  endfunction

  // Magnitude of an 8-bit signed joystick value; -128 maps to 128.
  function automatic logic [8:0] abs8(input logic [7:0] v);
    if (v[7]) begin
      return 9'd256 - {1'b0, v};
    end else begin
      return {1'b0, v};
    end
  endfunction

  // Joystick value sign-extended and scaled up to the axis width.
  function automatic logic [AXIS_W-1:0] joy_axis(input logic [7:0] v);
    logic signed [AXIS_W-1:0] t;
    t = AXIS_W'($signed(v));
    return t <<< (AXIS_W - 8);
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_old_stb;
  logic                     r_s1_vld;
  logic signed [10:0]       r_s1_dx;
  logic signed [10:0]       r_s1_dy;
  logic [2:0]               r_s1_btn;
  logic signed [AXIS_W-1:0] r_acc_x;
  logic signed [AXIS_W-1:0] r_acc_y;
  logic [2:0]               r_btn_hold;
  logic [AXIS_W-1:0]        r_ax;
  logic [AXIS_W-1:0]        r_ay;
  logic [2:0]               r_btn;
  logic                     r_active;
  logic                     r_upd;

  logic                     w_evt;
  logic                     w_override;
  logic                     w_add;
  logic                     w_s1_vld_nxt;
  logic signed [10:0]       w_dx;
  logic signed [10:0]       w_dy;
  logic signed [AXIS_W-1:0] w_acc_x_nxt;
  logic signed [AXIS_W-1:0] w_acc_y_nxt;
  logic [2:0]               w_btn_hold_nxt;
  logic [AXIS_W-1:0]        w_ax_nxt;
  logic [AXIS_W-1:0]        w_ay_nxt;
  logic [2:0]               w_btn_nxt;
  logic                     w_active_nxt;
  logic                     w_unused;

  // Bit 3 of the mouse status byte carries no information here.
  assign w_unused = ps2_mouse[3];

  assign w_evt = ps2_mouse[24] ^ r_old_stb;
  assign w_override = (r_state == ST_MOUSE) &&
                      ((abs8(joya[7:0]) > DZ) || (abs8(joya[15:8]) > DZ));
  assign w_dx = form_delta(ps2_mouse[4], ps2_mouse[15:8], ps2_mouse[6], 1'b0, sens);
  assign w_dy = form_delta(ps2_mouse[5], ps2_mouse[23:16], ps2_mouse[7], invert_y, sens);

  // Next state plus accumulator/button/pipeline-valid updates; an override
  // flushes everything in flight and beats any concurrent packet.
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_x_nxt    = r_acc_x;
    w_acc_y_nxt    = r_acc_y;
    w_btn_hold_nxt = r_btn_hold;
    w_s1_vld_nxt   = 1'b0;
    w_add          = 1'b0;
    case (r_state)
      ST_JOY: begin
        if (w_evt) begin
          w_state_nxt = ST_MOUSE;
        end else begin
          w_state_nxt = ST_JOY;
        end
      end
      ST_MOUSE: begin
        if (w_override) begin
          w_state_nxt = ST_JOY;
        end else begin
          w_state_nxt = ST_MOUSE;
        end
      end
      default: w_state_nxt = ST_JOY;
    endcase
    if (w_override) begin
      w_acc_x_nxt    = {AXIS_W{1'b0}};
      w_acc_y_nxt    = {AXIS_W{1'b0}};
      w_btn_hold_nxt = 3'b000;
      w_s1_vld_nxt   = 1'b0;
    end else begin
      w_s1_vld_nxt = w_evt;
      if (r_s1_vld) begin
        w_btn_hold_nxt = r_s1_btn;
        if (recenter) begin
          w_acc_x_nxt = {AXIS_W{1'b0}};
          w_acc_y_nxt = {AXIS_W{1'b0}};
        end else begin
          w_acc_x_nxt = sat_add(r_acc_x, r_s1_dx);
          w_acc_y_nxt = sat_add(r_acc_y, r_s1_dy);
          w_add       = 1'b1;
        end
      end else if (recenter) begin
        w_acc_x_nxt = {AXIS_W{1'b0}};
        w_acc_y_nxt = {AXIS_W{1'b0}};
      end else begin
        w_acc_x_nxt = r_acc_x;
        w_acc_y_nxt = r_acc_y;
      end
    end
  end

  // Output values for the coming cycle, chosen by who will own the axes.
  always_comb begin
    w_ax_nxt     = {AXIS_W{1'b0}};
    w_ay_nxt     = {AXIS_W{1'b0}};
    w_btn_nxt    = 3'b000;
    w_active_nxt = 1'b0;
    if (w_state_nxt == ST_MOUSE) begin
      w_ax_nxt     = w_acc_x_nxt;
      w_ay_nxt     = w_acc_y_nxt;
      w_btn_nxt    = w_btn_hold_nxt;
      w_active_nxt = 1'b1;
    end else begin
      w_ax_nxt     = joy_axis(joya[7:0]);
      w_ay_nxt     = joy_axis(joya[15:8]);
      w_btn_nxt    = 3'b000;
      w_active_nxt = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_JOY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Strobe history and stage-1 packet capture (sens/invert_y applied here).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_old_stb <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_dx   <= 11'sd0;
      r_s1_dy   <= 11'sd0;
      r_s1_btn  <= 3'b000;
    end else begin
      r_old_stb <= ps2_mouse[24];
      r_s1_vld  <= w_s1_vld_nxt;
      r_s1_dx   <= w_dx;
      r_s1_dy   <= w_dy;
      r_s1_btn  <= ps2_mouse[2:0];
    end
  end

  // Stage-2 accumulators and held mouse buttons.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_x    <= {AXIS_W{1'b0}};
      r_acc_y    <= {AXIS_W{1'b0}};
      r_btn_hold <= 3'b000;
    end else begin
      r_acc_x    <= w_acc_x_nxt;
      r_acc_y    <= w_acc_y_nxt;
      r_btn_hold <= w_btn_hold_nxt;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ax     <= {AXIS_W{1'b0}};
      r_ay     <= {AXIS_W{1'b0}};
      r_btn    <= 3'b000;
      r_active <= 1'b0;
      r_upd    <= 1'b0;
    end else begin
      r_ax     <= w_ax_nxt;
      r_ay     <= w_ay_nxt;
      r_btn    <= w_btn_nxt;
      r_active <= w_active_nxt;
      r_upd    <= w_add;
    end
  end

  assign ax           = r_ax;
  assign ay           = r_ay;
  assign btn          = r_btn;
  assign mouse_active = r_active;
  assign upd          = r_upd;

endmodule

// File: doc/mouse_axis_emu.md
Name: mouse_axis_emu

Overview:
- Parametrised mouse-to-analog-axis emulator; successor to the fixed 8-bit, ±10-step mouse paddle logic in the core top level.
- Converts PS/2 mouse packets into saturating X/Y absolute axes of width AXIS_W.
- Arbitrates between mouse emulation and the real analog joystick, and supplies mouse buttons as fire inputs.
- Sits between hps_io (ps2_mouse, joystick_analog_0) and the paddle mapping logic feeding the console core.

Parameters:
AXIS_W, 8, output axis width in bits; legal range 8..12
STEP_MAX, 10, maximum per-packet delta magnitude after scaling, in axis LSBs
DEAD_ZONE, 8, joystick magnitude (8-bit signed units) that must be exceeded to take control back from the mouse

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_mouse  in  25  hps_io mouse word: [24] toggle strobe, [7:6] Y/X overflow, [5:4] Y/X sign, [2:0] buttons, [15:8] X, [23:16] Y
joya  in  16  analog joystick: [7:0] X signed, [15:8] Y signed
sens  in  2  sensitivity: 0 = x1, 1 = x2, 2 = /2, 3 = /4
invert_y  in  1  negate the mouse Y delta
recenter  in  1  single-cycle pulse: zero both accumulators
ax  out  AXIS_W  signed X axis
ay  out  AXIS_W  signed Y axis
btn  out  3  mouse buttons {M,R,L}; 0 in JOY state
mouse_active  out  1  1 while in MOUSE state
upd  out  1  one-cycle pulse when ax/ay change because of a mouse packet

Behaviour:
- Reset (async on reset_n low): state JOY; accumulators 0; old_stb 0; pipeline valid 0; ax = ay = 0; btn 0; mouse_active 0; upd 0.
- Event detection: an event occurs in cycle n when ps2_mouse[24] != old_stb. old_stb updates every cycle.
- Delta formation: dx = 9-bit {X sign, X byte}; dy = 9-bit {Y sign, Y byte}.
- Overflow: if an overflow bit is set, that delta becomes +STEP_MAX or -STEP_MAX according to its sign bit.
- invert_y: negates dy before scaling.
- Scaling: x2 is a left shift by 1. /2 and /4 are arithmetic right shifts, so they round toward -inf.
- Clamp: the scaled delta is clamped to [-STEP_MAX, +STEP_MAX]. Intermediate width is 11 bits signed.
- Stage 1 (cycle n+1): register the clamped deltas, the buttons, and the valid bit.
- Stage 2 (cycle n+2): acc = sat(acc + delta) to [-2^(AXIS_W-1), 2^(AXIS_W-1)-1]. Outputs update and upd = 1 in this cycle. Event-to-output latency is 2 cycles.
- State JOY:
  - ax = joya[7:0] sign-extended and shifted left by (AXIS_W-8); ay likewise from joya[15:8].
  - btn = 0.
  - An event moves the state to MOUSE. That event's delta is accumulated normally, starting from the current acc.
- State MOUSE:
  - ax/ay = acc; btn = the buttons from the last packet.
  - If |joya X| > DEAD_ZONE or |joya Y| > DEAD_ZONE, go to JOY next cycle. Clear acc, btn, and all in-flight pipeline valid bits; no upd is issued for flushed packets.
  - |-128| is treated as 128.
- Simultaneous events:
  - Joystick override in the same cycle as an event or a stage-2 add: override wins and the packet is discarded.
  - recenter in the same cycle as a stage-2 add: acc = 0, no add, upd = 0.
  - recenter has no effect on state or btn. In JOY state it only clears acc.
- Back-to-back events on consecutive cycles are each accumulated; the pipeline is fully pipelined with no stall.
- No other hold or backpressure exists.
- sens and invert_y are sampled at stage 1. A mid-stream change affects only packets reaching stage 1 afterwards.

Test Plan:
- Reset, then toggle strobe with X=+5, sign 0, sens=0 -> mouse_active=1 and upd pulse exactly 2 cycles later; ax=5, ay=0.
- In MOUSE, 20 packets with X=+50 (clamps to +10) at AXIS_W=8 -> ax saturates at 127, never wraps. Then 30 packets with X=-50 -> ax=-128.
- sens=3, X=-3 (9'h1FD) -> delta -1 (floor), ax decrements by 1. Overflow bit set with sign 1 -> delta -10.
- Accumulate ax=40, then drive joya X=9 with DEAD_ZONE=8 -> next cycle mouse_active=0, ax=9 (AXIS_W=8) or 144 (AXIS_W=12), btn=0. Another packet restarts MOUSE from acc=0.
- recenter in the same cycle as a stage-2 add -> ax=ay=0, upd=0. Assert reset_n mid-pipeline -> all outputs 0 immediately, no upd after release.
- Four back-to-back packets on consecutive cycles with Y=+2, invert_y=1 -> four upd pulses; final ay=-8.
